seven_segment_scan_driver: RTL and testbench
============================================

// Module: seven_segment_scan_driver
// PURPOSE
//   Multi-digit, time-multiplexed seven-segment driver for the multiplier result path.
//   Captures a binary value on a load strobe and converts it to BCD with a sequential
//   shift-add-3 (double-dabble) engine; HEX_MODE bypasses the conversion.
//   Scans NUM_DIGITS common-anode digits through shared cathodes and blanks leading zeros.
//   Sits between the multiplier product register and the board display pins.
// PARAMETERS
//   NUM_DIGITS     4      digits driven (2..8)
//   DATA_W         8      input value width (4..24)
//   REFRESH_DIV    50000  clk cycles each digit stays lit (>=2)
//   HEX_MODE       0      0: decimal display via BCD conversion; 1: hex nibbles, no conversion
//   BLANK_LEADING  1      1: blank leading zero digits; digit 0 is never blanked
// PORTS
//   clk       in   1             system clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   value     in   DATA_W        binary value to display
//   load      in   1             capture request for value
//   busy      out  1             conversion in progress; load is ignored while high
//   overflow  out  1             value exceeds the displayable range
//   seg       out  7             cathodes {g,f,e,d,c,b,a}, active-low
//   an        out  NUM_DIGITS    anodes, active-low, one-hot; an[0] = least significant digit
// BEHAVIOUR
//   Reset (async, rst_n=0): seg=7'b1111111, an=all ones, busy=0, overflow=0. Digit
//     registers, scan index and refresh counter are cleared. Reset mid-conversion aborts
//     the conversion and discards the result.
//   Load: accepted on a rising edge E0 where load=1 and busy=0; value is registered at E0.
//     A load while busy=1 is dropped and does not queue.
//   Decimal mode:
//     - busy=1 from E0 through edge E0+DATA_W; one shift-add-3 step per cycle.
//     - At E0+DATA_W: digit registers, overflow and busy=0 update together.
//     - Load latency is DATA_W cycles; back-to-back loads are accepted every DATA_W+1 cycles.
//   Hex mode:
//     - Digits update at E0 and busy stays 0.
//     - digit i = value[4i+3:4i]. Nibbles beyond DATA_W read 0.
//   Overflow:
//     - Decimal: 1 when value >= 10^NUM_DIGITS.
//     - Hex: 1 when value >= 16^NUM_DIGITS.
//     - The displayed digits are the low NUM_DIGITS digits (truncated).
//     - overflow holds until the next accepted load.
//   Internal BCD width covers the full DATA_W range, e.g. 8 bits -> 3 digits.
//   States: IDLE --load--> CONV (counts DATA_W steps) --last step--> IDLE.
//     HEX_MODE never leaves IDLE.
//   Scan:
//     - Refresh counter runs 0..REFRESH_DIV-1 and wraps.
//     - On wrap, index advances 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
//     - an and seg are registered from the index and digit registers every cycle, so they
//       change on the same edge, one cycle after the index changes. No ghost cycle is allowed.
//   Decode (active-low):
//     - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010,
//       1111000, 0000000, 0010000.
//     - Digits A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
//   Blanking:
//     - Digit i (i>0) shows seg=1111111 when BLANK_LEADING=1 and digits i..NUM_DIGITS-1
//       are all 0; the anode is still driven.
//     - Digit 0 always displays.
//   Display registers update atomically, so a scan never mixes old and new digits.
// TESTING (REFRESH_DIV=4, NUM_DIGITS=4, DATA_W=8 unless noted)
//   1. Reset release, no load -> an=1110 seg=1000000 at the first edge.
//      Digits 1-3 are blank, an rotates every 4 cycles.
//   2. load value=255 -> busy high exactly 8 cycles.
//      Digits then read 0255: digit3 blank, then 2 (0100100), 5 (0010010), 5; overflow=0.
//   3. load value=9 with BLANK_LEADING=0 -> four digits shown: 0, 0, 0, 9 (0010000).
//   4. load during busy (value=17 while converting 200) -> ignored; display shows 200.
//   5. NUM_DIGITS=2, load 150 -> overflow=1, display reads 50.
//      Then load 42 -> overflow=0.
//   6. HEX_MODE=1, load 8'hAF -> same-edge update, busy=0.
//      Display shows F (0001110) and A (0001000); digits 2-3 blank.
//   7. Assert rst_n low mid-conversion -> outputs reset at once.
//      Next load converts correctly.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment driver: captures a binary value, converts it to BCD
// with a serial double-dabble engine (or shows raw hex nibbles), and scans the digits.
module seven_segment_scan_driver #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned HEX_MODE      = 0,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    // Decimal digits needed to hold the largest DATA_W-bit value.
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (longint'(1) << w) - 1;
        n = 1;
        while (m >= 10) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    localparam int unsigned BCD_DIGITS = bcd_digits(DATA_W);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned DIG_W      = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned REF_W      = $clog2(REFRESH_DIV);
    localparam int unsigned STEP_W     = $clog2(DATA_W + 1);
    localparam logic [63:0] LIMIT      = (HEX_MODE != 0) ? (64'd1 << (4 * NUM_DIGITS))
                                                         : 64'(10 ** NUM_DIGITS);

    typedef enum logic {S_IDLE, S_CONV} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+DATA_W-1:0] shifted;
    logic [3:0]              nib;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
    always_comb begin
        bcd_adj = '0;
        nib     = '0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            nib = bcd_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Load capture and conversion control; results publish together on the last step.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    val_d = value;
                    if (HEX_MODE != 0) begin
                        dig_d = DIG_W'(value);
                        ovf_d = 64'(value) >= LIMIT;
                    end else begin
                        bin_d   = value;
                        bcd_d   = '0;
                        step_d  = '0;
                        busy_d  = 1'b1;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                bin_d  = shifted[DATA_W-1:0];
                bcd_d  = shifted[BCD_W+DATA_W-1:DATA_W];
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(DATA_W - 1)) begin
                    dig_d   = DIG_W'(shifted[BCD_W+DATA_W-1:DATA_W]);
                    ovf_d   = 64'(val_q) >= LIMIT;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;
    logic [3:0]            cur_dig;
    logic                  cur_blank;

    // Refresh/scan: anode and cathodes are registered from the same index on the same edge.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        zero_run = 1'b1;
        blank    = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (dig_q[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LEADING != 0) && (i != 0) && zero_run;
        end

        cur_dig   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig   = dig_q[4*i +: 4];
                cur_blank = blank[i];
            end
        end

        seg_d = cur_blank ? 7'b1111111 : decode(cur_dig);
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            val_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            val_q   <= val_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver: four configurations share one clock,
// expected displays are queued at load time and compared once each scan settles.
module tb_seven_segment_scan_driver;

    localparam int unsigned RD = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NI = 4;

    typedef struct packed {
        logic        ovf;
        logic [55:0] segs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [DW-1:0] value_r [NI];
    logic          load_r  [NI];
    logic          busy_w  [NI];
    logic          ovf_w   [NI];
    logic [6:0]    seg_w   [NI];
    logic [7:0]    an_w    [NI];
    logic [3:0]    an_0, an_1, an_3;
    logic [1:0]    an_2;

    assign an_w[0] = {4'hF, an_0};
    assign an_w[1] = {4'hF, an_1};
    assign an_w[2] = {6'h3F, an_2};
    assign an_w[3] = {4'hF, an_3};

    int unsigned nd_of  [NI] = '{4, 4, 2, 4};
    int unsigned hex_of [NI] = '{0, 0, 0, 1};
    int unsigned bl_of  [NI] = '{1, 0, 1, 1};
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t        sb_q [$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seven_segment_scan_driver #(.NUM_DIGITS(4), .DATA_W(DW), .REFRESH_DIV(RD),
        .HEX_MODE(0), .BLANK_LEADING(1)) u_dec (
        .clk(clk), .rst_n(rst_n), .value(value_r[0]), .load(load_r[0]),
        .busy(busy_w[0]), .overflow(ovf_w[0]), .seg(seg_w[0]), .an(an_0));

    seven_segment_scan_driver #(.NUM_DIGITS(4), .DATA_W(DW), .REFRESH_DIV(RD),
        .HEX_MODE(0), .BLANK_LEADING(0)) u_noblank (
        .clk(clk), .rst_n(rst_n), .value(value_r[1]), .load(load_r[1]),
        .busy(busy_w[1]), .overflow(ovf_w[1]), .seg(seg_w[1]), .an(an_1));

    seven_segment_scan_driver #(.NUM_DIGITS(2), .DATA_W(DW), .REFRESH_DIV(RD),
        .HEX_MODE(0), .BLANK_LEADING(1)) u_nd2 (
        .clk(clk), .rst_n(rst_n), .value(value_r[2]), .load(load_r[2]),
        .busy(busy_w[2]), .overflow(ovf_w[2]), .seg(seg_w[2]), .an(an_2));

    seven_segment_scan_driver #(.NUM_DIGITS(4), .DATA_W(DW), .REFRESH_DIV(RD),
        .HEX_MODE(1), .BLANK_LEADING(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .value(value_r[3]), .load(load_r[3]),
        .busy(busy_w[3]), .overflow(ovf_w[3]), .seg(seg_w[3]), .an(an_3));

    // Reference display: digits by division (or nibbles), then leading-zero blanking.
    function automatic exp_t model(input int sel, input int unsigned v);
        exp_t        e;
        int unsigned d [8];
        int unsigned dv;
        longint unsigned lim;
        bit          zr;
        dv = 1;
        for (int i = 0; i < 8; i++) begin
            d[i] = (hex_of[sel] != 0) ? ((v >> (4 * i)) & 15) : ((v / dv) % 10);
            if (i < 7) dv = dv * 10;
        end
        lim = (hex_of[sel] != 0) ? (longint'(1) << (4 * nd_of[sel])) : longint'(10 ** nd_of[sel]);
        e.ovf  = (longint'(v) >= lim);
        e.segs = '1;
        zr = 1'b1;
        for (int i = int'(nd_of[sel]) - 1; i >= 0; i--) begin
            zr = zr && (d[i] == 0);
            e.segs[7*i +: 7] = (bl_of[sel] != 0 && i > 0 && zr) ? 7'h7F : seg_tab[d[i]];
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int sel, input int unsigned v, input bit push);
        @(negedge clk);
        value_r[sel] = DW'(v);
        load_r[sel]  = 1'b1;
        @(posedge clk);
        #1;
        load_r[sel]  = 1'b0;
        if (push) sb_q.push_back(model(sel, v));
    endtask

    task automatic wait_idle(input int sel, output int n);
        n = 0;
        while (busy_w[sel] && n < 64) begin
            n++;
            tick();
        end
        if (n >= 64) check_eq($sformatf("busy_timeout_%0d", sel), 64'(busy_w[sel]), 64'd0);
    endtask

    task automatic check_display(input int sel, input string tag);
        exp_t       e;
        int         k;
        logic [7:0] an_exp;
        if (sb_q.size() == 0) begin
            check_eq($sformatf("%s_sb_empty", tag), 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        tick();
        check_eq($sformatf("%s_ovf", tag), 64'(ovf_w[sel]), 64'(e.ovf));
        for (int d = 0; d < int'(nd_of[sel]); d++) begin
            an_exp = 8'hFF & ~(8'd1 << d);
            k = 0;
            while (an_w[sel] !== an_exp && k < 64) begin
                k++;
                tick();
            end
            check_eq($sformatf("%s_an%0d", tag, d), 64'(an_w[sel]), 64'(an_exp));
            check_eq($sformatf("%s_seg%0d", tag, d), 64'(seg_w[sel]), 64'(e.segs[7*d +: 7]));
        end
    endtask

    int          n;
    int unsigned dec_vals [6];

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < int'(NI); i++) begin
            value_r[i] = '0;
            load_r[i]  = 1'b0;
        end
        dec_vals = '{0, 7, 100, 58, 9, $urandom_range(0, 255)};

        // Reset state and first scan edge
        repeat (2) tick();
        check_eq("rst_seg", 64'(seg_w[0]), 64'h7F);
        check_eq("rst_an", 64'(an_w[0]), 64'hFF);
        check_eq("rst_busy", 64'(busy_w[0]), 64'd0);
        check_eq("rst_ovf", 64'(ovf_w[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("first_an", 64'(an_w[0]), 64'hFE);
        check_eq("first_seg", 64'(seg_w[0]), 64'h40);
        repeat (3) tick();
        check_eq("an_hold", 64'(an_w[0]), 64'hFE);
        tick();
        check_eq("an_rotate", 64'(an_w[0]), 64'hFD);
        check_eq("blank_d1", 64'(seg_w[0]), 64'h7F);

        // 255 and a spread of decimal values
        do_load(0, 255, 1);
        wait_idle(0, n);
        check_eq("busy_cycles_255", 64'(n), 64'd8);
        check_display(0, "dec255");
        foreach (dec_vals[i]) begin
            do_load(0, dec_vals[i], 1);
            wait_idle(0, n);
            check_eq($sformatf("busy_cycles_%0d", dec_vals[i]), 64'(n), 64'd8);
            check_display(0, $sformatf("dec%0d", dec_vals[i]));
        end

        // No leading-zero blanking
        do_load(1, 9, 1);
        wait_idle(1, n);
        check_display(1, "noblank9");

        // Load while busy is dropped
        do_load(0, 200, 1);
        @(negedge clk);
        value_r[0] = 8'd17;
        load_r[0]  = 1'b1;
        tick();
        load_r[0]  = 1'b0;
        wait_idle(0, n);
        check_eq("busy_after_stray", 64'(n), 64'd7);
        check_display(0, "dec200");

        // Two-digit overflow boundaries
        do_load(2, 42, 1);  wait_idle(2, n); check_display(2, "nd2_42");
        do_load(2, 150, 1); wait_idle(2, n); check_display(2, "nd2_150");
        do_load(2, 99, 1);  wait_idle(2, n); check_display(2, "nd2_99");
        do_load(2, 100, 1); wait_idle(2, n); check_display(2, "nd2_100");

        // Hex mode updates on the load edge
        do_load(3, 8'hAF, 1);
        check_eq("hex_busy", 64'(busy_w[3]), 64'd0);
        check_display(3, "hexAF");
        do_load(3, 8'h05, 1);
        check_display(3, "hex05");

        // Reset mid-conversion
        do_load(0, 123, 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy_w[0]), 64'd0);
        check_eq("midrst_seg", 64'(seg_w[0]), 64'h7F);
        check_eq("midrst_an", 64'(an_w[0]), 64'hFF);
        check_eq("midrst_ovf", 64'(ovf_w[2]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(0, 77, 1);
        wait_idle(0, n);
        check_eq("busy_cycles_77", 64'(n), 64'd8);
        check_display(0, "dec77");
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
